// File: rtl/spi_slave_word_link_pkg.sv
// Shared definitions for the SPI slave word link: FSM state encodings.
package spi_slave_word_link_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_ACTIVE = 2'd2;
  localparam state_t ST_REFILL = 2'd3;

endpackage

// File: rtl/spi_slave_word_link_if.sv
// SPI pins plus RX/TX word-buffer handshake, grouped for the SPI slave link.
interface spi_slave_word_link_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  rx_wr;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  tx_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  busy;

  modport slave (
    input  sclk, cs_n, mosi, tx_data,
    output miso, rx_wr, rx_data, tx_oe, busy
  );

  modport master (
    output sclk, cs_n, mosi, tx_data,
    input  miso, rx_wr, rx_data, tx_oe, busy
  );

endinterface

// File: rtl/spi_slave_word_link_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input with rise/fall pulses.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              lvl;

  assign lvl = sync_q[STAGES-1];

  // Synchroniser chain plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= lvl;
    end
  end

  assign rise_o = lvl & ~prev_q;
  assign fall_o = ~lvl & prev_q;

endmodule

// File: rtl/spi_slave_word_link.sv
// SPI mode-0 slave, MSB first: assembles RX words and shifts out TX words
// fetched from the TX buffer, one per received word.
module spi_slave_word_link
  import spi_slave_word_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_slave_word_link_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-2:0] rx_sr_q, rx_sr_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_wr_q, rx_wr_d;
  logic                  miso_q, miso_d;
  logic                  busy_q, busy_d;
  logic                  armed_q, armed_d;
  logic                  skip_q, skip_d;
  logic                  tx_oe;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.cs_n),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // mosi needs the same latency as sclk but no edge detection.
  always_ff @(posedge clk) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Next-state logic: word assembly, TX fetch/shift and frame control.
  // armed follows cs_rise: the synchroniser resets low, so the first cycle
  // it sees cs_n high is always a rise.
  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;
    rx_data_d = rx_data_q;
    rx_wr_d   = 1'b0;
    miso_d    = miso_q;
    busy_d    = busy_q;
    armed_d   = armed_q | cs_rise;
    skip_d    = skip_q;
    tx_oe     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          tx_oe   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_sr_d = bus.tx_data;
        miso_d  = bus.tx_data[DATA_WIDTH-1];
        skip_d  = 1'b0;
        state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (sclk_rise) begin
          rx_sr_d = {rx_sr_q[DATA_WIDTH-3:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d = {rx_sr_q, mosi_s};
            rx_wr_d   = 1'b1;
            bit_cnt_d = '0;
            tx_oe     = 1'b1;
            state_d   = ST_REFILL;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          // The fall right after a refill keeps the freshly loaded MSB.
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            tx_sr_d = tx_sr_q << 1;
            miso_d  = tx_sr_q[DATA_WIDTH-2];
          end
        end
      end
      ST_REFILL: begin
        tx_sr_d = bus.tx_data;
        miso_d  = bus.tx_data[DATA_WIDTH-1];
        skip_d  = 1'b1;
        state_d = ST_ACTIVE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Deselect overrides everything except a word completing in this cycle.
    if (cs_rise) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      miso_d    = 1'b0;
      bit_cnt_d = '0;
      rx_sr_d   = '0;
      skip_d    = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
      rx_data_q <= '0;
      rx_wr_q   <= 1'b0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
      armed_q   <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      bit_cnt_q <= bit_cnt_d;
      rx_data_q <= rx_data_d;
      rx_wr_q   <= rx_wr_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
      armed_q   <= armed_d;
      skip_q    <= skip_d;
    end
  end

  assign bus.miso    = miso_q;
  assign bus.rx_wr   = rx_wr_q;
  assign bus.rx_data = rx_data_q;
  assign bus.tx_oe   = tx_oe;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_spi_slave_word_link.sv
// Directed bench for spi_slave_word_link: table of single-word frames plus
// hand-written back-to-back, deselect, coincident-edge and reset sequences.
module tb_spi_slave_word_link;

  localparam int unsigned DW   = 32;
  localparam int unsigned SYNC = 2;
  localparam int unsigned HALF = 8;

  typedef struct {
    logic [31:0] mosi_w;
    logic [31:0] tx_w;
    logic [31:0] exp_rx;
    logic [31:0] exp_miso;
  } vec_t;

  logic clk;
  logic rst;

  spi_slave_word_link_if #(.DATA_WIDTH(DW)) bus ();

  spi_slave_word_link #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned tx_oe_cnt = 0;
  int unsigned rx_wr_cnt = 0;
  int unsigned overlap_cnt = 0;
  logic [31:0] tx_q[$];
  logic [31:0] rx_got[$];

  // TX buffer model: registered output, valid the cycle after tx_oe.
  always @(posedge clk) begin
    if (rst) bus.tx_data <= '0;
    else if (bus.tx_oe) begin
      if (tx_q.size() != 0) bus.tx_data <= tx_q.pop_front();
      else                  bus.tx_data <= '0;
    end
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.tx_oe) tx_oe_cnt++;
    if (bus.rx_wr) begin
      rx_wr_cnt++;
      rx_got.push_back(bus.rx_data);
    end
    if (bus.tx_oe && bus.rx_wr) overlap_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic wait_neg(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Lower cs_n and check the first fetch, busy and the first MSB on miso.
  task automatic select_frame(input logic [31:0] tx_w, input logic [31:0] tx_w2);
    int unsigned oe0;
    tx_q.delete();
    tx_q.push_back(tx_w);
    tx_q.push_back(tx_w2);
    rx_got.delete();
    oe0 = tx_oe_cnt;
    bus.cs_n = 1'b0;
    wait_neg(SYNC + 2);
    #1;
    check("sel_tx_oe_count", tx_oe_cnt - oe0, 1);
    check("sel_busy", bus.busy, 1);
    wait_neg(4);
    #1;
    check("sel_miso_msb", bus.miso, tx_w[31]);
  endtask

  // Master shifts out the top nbits of m, sampling miso before each rise.
  task automatic send_bits(input logic [31:0] m, input int unsigned nbits,
                           output logic [31:0] mw);
    mw = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      bus.mosi = m[31-i];
      wait_neg(HALF);
      mw[31-i] = bus.miso;
      bus.sclk = 1'b1;
      wait_neg(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic deselect();
    wait_neg(HALF);
    bus.cs_n = 1'b1;
    wait_neg(SYNC + 2);
    #1;
    check("desel_busy", bus.busy, 0);
    check("desel_miso", bus.miso, 0);
    wait_neg(6);
  endtask

  vec_t vecs[4];

  initial begin
    logic [31:0] mw, mw2;
    int unsigned oe0, rx0;

    vecs[0] = '{mosi_w: 32'hA5A5_0F0F, tx_w: 32'h1234_5678, exp_rx: 32'hA5A5_0F0F, exp_miso: 32'h1234_5678};
    vecs[1] = '{mosi_w: 32'hFFFF_FFFF, tx_w: 32'h8000_0001, exp_rx: 32'hFFFF_FFFF, exp_miso: 32'h8000_0001};
    vecs[2] = '{mosi_w: 32'h0000_0000, tx_w: 32'hFFFF_FFFF, exp_rx: 32'h0000_0000, exp_miso: 32'hFFFF_FFFF};
    vecs[3] = '{mosi_w: 32'h6996_C33C, tx_w: 32'h0F0F_F0F0, exp_rx: 32'h6996_C33C, exp_miso: 32'h0F0F_F0F0};

    rst = 1'b1;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    wait_neg(4);
    #1;
    check("rst_miso", bus.miso, 0);
    check("rst_rx_wr", bus.rx_wr, 0);
    check("rst_tx_oe", bus.tx_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rx_data", bus.rx_data, 0);
    rst = 1'b0;
    wait_neg(6);

    // Single-word frames from the table.
    for (int unsigned v = 0; v < 4; v++) begin
      oe0 = tx_oe_cnt;
      rx0 = rx_wr_cnt;
      select_frame(vecs[v].tx_w, 32'h0);
      send_bits(vecs[v].mosi_w, 32, mw);
      #1;
      check("vec_rx_wr_count", rx_wr_cnt - rx0, 1);
      check("vec_rx_data", (rx_got.size() != 0) ? rx_got[0] : 32'hXXXX_XXXX, vecs[v].exp_rx);
      check("vec_miso_word", mw, vecs[v].exp_miso);
      check("vec_tx_oe_total", tx_oe_cnt - oe0, 2);
      deselect();
    end

    // Back-to-back words in one frame.
    oe0 = tx_oe_cnt;
    rx0 = rx_wr_cnt;
    select_frame(32'h8000_0001, 32'h7FFF_FFFE);
    send_bits(32'h0000_0001, 32, mw);
    send_bits(32'hFFFF_FFFF, 32, mw2);
    #1;
    check("b2b_rx_wr_count", rx_wr_cnt - rx0, 2);
    check("b2b_rx0", (rx_got.size() > 0) ? rx_got[0] : 32'hXXXX_XXXX, 32'h0000_0001);
    check("b2b_rx1", (rx_got.size() > 1) ? rx_got[1] : 32'hXXXX_XXXX, 32'hFFFF_FFFF);
    check("b2b_miso0", mw, 32'h8000_0001);
    check("b2b_miso1", mw2, 32'h7FFF_FFFE);
    check("b2b_tx_oe_total", tx_oe_cnt - oe0, 3);
    deselect();

    // Deselect after 17 bits: partial word dropped, next frame clean.
    rx0 = rx_wr_cnt;
    select_frame(32'hFFFF_FFFF, 32'h0);
    send_bits(32'hDEAD_BEEF, 17, mw);
    #1;
    check("part_miso_before_desel", bus.miso, 1);
    deselect();
    check("part_no_rx_wr", rx_wr_cnt - rx0, 0);
    select_frame(32'h2468_ACE0, 32'h0);
    send_bits(32'h1357_9BDF, 32, mw);
    #1;
    check("part_next_rx", (rx_got.size() != 0) ? rx_got[0] : 32'hXXXX_XXXX, 32'h1357_9BDF);
    check("part_next_miso", mw, 32'h2468_ACE0);
    deselect();

    // Final sclk rise and cs_n rise land in the same cycle.
    oe0 = tx_oe_cnt;
    rx0 = rx_wr_cnt;
    select_frame(32'h5555_AAAA, 32'h0);
    send_bits(32'hC001_D00D, 31, mw);
    bus.mosi = 1'b1;
    wait_neg(HALF);
    bus.sclk = 1'b1;
    bus.cs_n = 1'b1;
    wait_neg(HALF);
    bus.sclk = 1'b0;
    #1;
    check("coinc_rx_wr_count", rx_wr_cnt - rx0, 1);
    check("coinc_rx_data", (rx_got.size() != 0) ? rx_got[0] : 32'hXXXX_XXXX, 32'hC001_D00D);
    check("coinc_busy", bus.busy, 0);
    check("coinc_miso", bus.miso, 0);
    check("coinc_tx_oe_total", tx_oe_cnt - oe0, 2);
    wait_neg(6);

    // Reset mid-word; cs_n stays low so the link must stay idle.
    select_frame(32'h0F0F_0F0F, 32'h0);
    send_bits(32'hAAAA_AAAA, 10, mw);
    rst = 1'b1;
    wait_neg(3);
    rst = 1'b0;
    oe0 = tx_oe_cnt;
    rx0 = rx_wr_cnt;
    wait_neg(4);
    send_bits(32'hFFFF_0000, 32, mw);
    #1;
    check("rstmid_no_tx_oe", tx_oe_cnt - oe0, 0);
    check("rstmid_no_rx_wr", rx_wr_cnt - rx0, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_miso", bus.miso, 0);
    bus.cs_n = 1'b1;
    wait_neg(8);
    select_frame(32'hBEEF_CAFE, 32'h0);
    send_bits(32'h0123_4567, 32, mw);
    #1;
    check("rstmid_after_rx", (rx_got.size() != 0) ? rx_got[0] : 32'hXXXX_XXXX, 32'h0123_4567);
    check("rstmid_after_miso", mw, 32'hBEEF_CAFE);
    deselect();

    check("oe_wr_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
